vga_text_engine: RTL and testbench

VGA_TEXT_ENGINE -- requirements
Module: vga_text_engine

---
 rtl/vga_text_engine.sv | 250 +++++++++++++++++++++++++
 tb/tb_vga_text_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_engine.sv
// ---------------------------------------------------------------------------
// vga_text_engine
//
// Purpose: generates VGA timing and renders a character grid from a VRAM of
// {colour, glyph} words and an external font ROM. The engine can also run in
// image mode, where each cell shows the low byte of its VRAM word. A blinking
// cursor can be placed on one cell. Rendering is a 5-stage pipeline, and all
// display outputs are aligned to the pixel-colour stage.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high
//   vram_rd_en   VRAM read strobe (registered, stage P1)
//   vram_addr    VRAM word address (registered, stage P1)
//   vram_data    [18:16] colour, [15:0] glyph; valid 1 clk after strobe
//   font_addr    {glyph[7:0], glyph row} (registered, stage P3)
//   font_row     glyph row bits, MSB = leftmost pixel; valid 1 clk after addr
//   mode         0 = text, 1 = image (latched at frame start)
//   cursor_en    cursor enable (latched at frame start)
//   cursor_col   cursor cell column (latched at frame start)
//   cursor_row   cursor cell row (latched at frame start)
//   hsync/vsync  sync outputs, active level SYNC_POL, aligned with rgb_out
//   blank        high outside the visible region, aligned with rgb_out
//   rgb_out      RRRGGGBB pixel (registered, stage P5)
//   frame_start  one-clk pulse while the counters sit at (0,0)
// ---------------------------------------------------------------------------
module vga_text_engine #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int CHAR_W_LOG2  = 4,
    parameter int CHAR_H_LOG2  = 4,
    parameter int TEXT_COLS    = 40,
    parameter int TEXT_ROWS    = 30,
    parameter int VRAM_AW      = 12,
    parameter int BLINK_FRAMES = 30,
    parameter bit SYNC_POL     = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         vram_rd_en,
    output logic [VRAM_AW-1:0]           vram_addr,
    input  logic [18:0]                  vram_data,
    output logic [8+CHAR_H_LOG2-1:0]     font_addr,
    input  logic [(1<<CHAR_W_LOG2)-1:0]  font_row,
    input  logic                         mode,
    input  logic                         cursor_en,
    input  logic [7:0]                   cursor_col,
    input  logic [7:0]                   cursor_row,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         blank,
    output logic [7:0]                   rgb_out,
    output logic                         frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int BL_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [HC_W-1:0] HC_LAST = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] HC_ACT  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HC_W-1:0] COLS_C  = HC_W'(TEXT_COLS);
    localparam logic [VC_W-1:0] VC_LAST = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] VC_ACT  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END  = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VC_W-1:0] ROWS_C  = VC_W'(TEXT_ROWS);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_FRAMES - 1);

    // 3-bit colour index to RRRGGGBB by bit replication
    function automatic logic [7:0] expand_colour(input logic [2:0] c);
        return {{3{c[2]}}, {3{c[1]}}, {2{c[0]}}};
    endfunction

    // counters and frame-level state
    logic [HC_W-1:0]    r_hc;
    logic [VC_W-1:0]    r_vc;
    logic [VRAM_AW-1:0] r_row_base;
    logic [BL_W-1:0]    r_blink_cnt;
    logic               r_blink_phase;
    logic               r_mode;
    logic               r_cur_en;
    logic [7:0]         r_cur_col;
    logic [7:0]         r_cur_row;

    logic                   w_h_last, w_v_last, w_origin;
    logic [HC_W-1:0]        w_col;
    logic [VC_W-1:0]        w_row;
    logic [CHAR_W_LOG2-1:0] w_cx;
    logic [CHAR_H_LOG2-1:0] w_cy;
    logic                   w_visible, w_grid, w_rd, w_hs, w_vs, w_hit;
    logic                   w_cur_en;
    logic [7:0]             w_cur_col, w_cur_row;

    assign w_h_last  = (r_hc == HC_LAST);
    assign w_v_last  = (r_vc == VC_LAST);
    assign w_origin  = (r_hc == '0) && (r_vc == '0);
    assign w_col     = r_hc >> CHAR_W_LOG2;
    assign w_row     = r_vc >> CHAR_H_LOG2;
    assign w_cx      = r_hc[CHAR_W_LOG2-1:0];
    assign w_cy      = r_vc[CHAR_H_LOG2-1:0];
    assign w_visible = (r_hc < HC_ACT) && (r_vc < VC_ACT);
    assign w_grid    = (w_col < COLS_C) && (w_row < ROWS_C);
    assign w_rd      = w_visible && w_grid;
    assign w_hs      = ((r_hc >= HS_BEG) && (r_hc < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign w_vs      = ((r_vc >= VS_BEG) && (r_vc < VS_END)) ? SYNC_POL : ~SYNC_POL;

    // On the frame_start cycle the freshly sampled cursor inputs already
    // apply, so pixel (0,0) sees the same cursor as the rest of its frame.
    assign w_cur_en  = w_origin ? cursor_en  : r_cur_en;
    assign w_cur_col = w_origin ? cursor_col : r_cur_col;
    assign w_cur_row = w_origin ? cursor_row : r_cur_row;
    assign w_hit     = w_cur_en && (16'(w_col) == 16'(w_cur_col))
                                && (16'(w_row) == 16'(w_cur_row));

    // Gated by reset so the pulse cannot appear while the block is held.
    assign frame_start = w_origin & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_row_base    <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_mode        <= 1'b0;
            r_cur_en      <= 1'b0;
            r_cur_col     <= '0;
            r_cur_row     <= '0;
        end else begin
            if (w_origin) begin
                r_mode    <= mode;
                r_cur_en  <= cursor_en;
                r_cur_col <= cursor_col;
                r_cur_row <= cursor_row;
            end
            if (w_h_last) begin
                r_hc <= '0;
                if (w_v_last) begin
                    r_vc       <= '0;
                    r_row_base <= '0;
                    if (r_blink_cnt == BL_LAST) begin
                        r_blink_cnt   <= '0;
                        r_blink_phase <= ~r_blink_phase;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + BL_W'(1);
                    end
                end else begin
                    r_vc <= r_vc + VC_W'(1);
                    // last glyph line of a character row: next line starts a new row
                    if (&w_cy)
                        r_row_base <= r_row_base + VRAM_AW'(TEXT_COLS);
                end
            end else begin
                r_hc <= r_hc + HC_W'(1);
            end
        end
    end

    // pipeline registers; side-band shift registers: bit 0 = P1 ... bit 4 = P5
    logic                   r_vram_rd_en_p1;
    logic [VRAM_AW-1:0]     r_vram_addr_p1;
    logic [CHAR_W_LOG2-1:0] r_cx_p1, r_cx_p2, r_cx_p3, r_cx_p4;
    logic [CHAR_H_LOG2-1:0] r_cy_p1, r_cy_p2;
    logic [8+CHAR_H_LOG2-1:0] r_font_addr_p3;
    logic [2:0]             r_colour_p3, r_colour_p4;
    logic [7:0]             r_img_p3, r_img_p4;
    logic [7:0]             r_rgb_p5;
    logic [4:0]             r_hs_d, r_vs_d, r_blank_d, r_grid_d, r_hit_d;

    logic [CHAR_W_LOG2-1:0] w_bit_idx;
    logic                   w_bit;
    logic [7:0]             w_pix;
    logic                   w_unused;

    // FONT_W-1-cx for a power-of-two width is the bitwise complement of cx
    assign w_bit_idx = ~r_cx_p4;
    assign w_bit     = font_row[w_bit_idx] ^ (r_hit_d[3] & r_blink_phase);
    assign w_pix     = r_mode ? r_img_p4 : (w_bit ? expand_colour(r_colour_p4) : 8'h00);
    assign w_unused  = ^vram_data[15:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vram_rd_en_p1 <= 1'b0;
            r_vram_addr_p1  <= '0;
            r_cx_p1         <= '0;
            r_cx_p2         <= '0;
            r_cx_p3         <= '0;
            r_cx_p4         <= '0;
            r_cy_p1         <= '0;
            r_cy_p2         <= '0;
            r_font_addr_p3  <= '0;
            r_colour_p3     <= '0;
            r_colour_p4     <= '0;
            r_img_p3        <= '0;
            r_img_p4        <= '0;
            r_rgb_p5        <= '0;
            r_hs_d          <= {5{~SYNC_POL}};
            r_vs_d          <= {5{~SYNC_POL}};
            r_blank_d       <= '1;
            r_grid_d        <= '0;
            r_hit_d         <= '0;
        end else begin
            // P0 -> P1: VRAM request; address holds when no read is issued
            r_vram_rd_en_p1 <= w_rd;
            if (w_rd)
                r_vram_addr_p1 <= r_row_base + VRAM_AW'(w_col);
            r_cx_p1   <= w_cx;
            r_cy_p1   <= w_cy;
            r_hs_d    <= {r_hs_d[3:0], w_hs};
            r_vs_d    <= {r_vs_d[3:0], w_vs};
            r_blank_d <= {r_blank_d[3:0], ~w_visible};
            r_grid_d  <= {r_grid_d[3:0], w_grid};
            r_hit_d   <= {r_hit_d[3:0], w_hit};
            // P1 -> P2: VRAM access in flight
            r_cx_p2 <= r_cx_p1;
            r_cy_p2 <= r_cy_p1;
            // P2 -> P3: VRAM word consumed, font lookup issued
            r_font_addr_p3 <= {vram_data[7:0], r_cy_p2};
            r_colour_p3    <= vram_data[18:16];
            r_img_p3       <= vram_data[7:0];
            r_cx_p3        <= r_cx_p2;
            // P3 -> P4: font access in flight
            r_colour_p4 <= r_colour_p3;
            r_img_p4    <= r_img_p3;
            r_cx_p4     <= r_cx_p3;
            // P4 -> P5: pixel colour, masked outside the visible text grid
            r_rgb_p5 <= (r_blank_d[3] || !r_grid_d[3]) ? 8'h00 : w_pix;
        end
    end

    assign vram_rd_en = r_vram_rd_en_p1;
    assign vram_addr  = r_vram_addr_p1;
    assign font_addr  = r_font_addr_p3;
    assign rgb_out    = r_rgb_p5;
    assign hsync      = r_hs_d[4];
    assign vsync      = r_vs_d[4];
    assign blank      = r_blank_d[4];

endmodule

// File: tb/tb_vga_text_engine.sv
module tb_vga_text_engine;

    localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
    localparam int VA = 48, VFP = 2, VSW = 3, VBP = 2;
    localparam int HT = HA + HFP + HSW + HBP;   // 80
    localparam int VT = VA + VFP + VSW + VBP;   // 55
    localparam int COLS = 3, ROWS = 2, BLINK = 2;
    localparam int FRAME = HT * VT;             // 4400

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vram_rd_en;
    logic [11:0] vram_addr;
    logic [18:0] vram_data = '0;
    logic [11:0] font_addr;
    logic [15:0] font_row = '0;
    logic        mode = 1'b0;
    logic        cursor_en = 1'b0;
    logic [7:0]  cursor_col = '0;
    logic [7:0]  cursor_row = '0;
    logic        hsync, vsync, blank, frame_start;
    logic [7:0]  rgb_out;

    vga_text_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CHAR_W_LOG2(4), .CHAR_H_LOG2(4),
        .TEXT_COLS(COLS), .TEXT_ROWS(ROWS),
        .VRAM_AW(12), .BLINK_FRAMES(BLINK), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset),
        .vram_rd_en(vram_rd_en), .vram_addr(vram_addr), .vram_data(vram_data),
        .font_addr(font_addr), .font_row(font_row),
        .mode(mode), .cursor_en(cursor_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .hsync(hsync), .vsync(vsync), .blank(blank),
        .rgb_out(rgb_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    logic [18:0] vram [0:4095];
    logic [15:0] font [0:4095];

    // synchronous memories: data valid one clock after the address
    always @(posedge clk) begin
        vram_data <= vram[vram_addr];
        font_row  <= font[font_addr];
    end

    typedef struct { int f; int h; int v; logic [7:0] rgb; logic hs; logic vs; logic bl; } pix_t;
    typedef struct { int h; int v; logic rd; logic [11:0] addr; } adr_t;
    typedef struct { int f; int h; int v; logic [7:0] rgb; } probe_t;

    pix_t   q_pix[$];
    adr_t   q_adr[$];
    probe_t probes[16];

    int checks = 0;
    int errors = 0;

    int          m_hc, m_vc, m_f;
    logic        m_mode, m_cen;
    int          m_ccol, m_crow;
    logic [11:0] m_last_addr;

    task automatic check(input string name, input int f, input int h, input int v,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s frame=%0d hc=%0d vc=%0d got=%0h want=%0h", name, f, h, v, act, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_rgb",   -1, -1, -1, 32'(rgb_out),     32'h0);
        check("rst_blank", -1, -1, -1, 32'(blank),       32'h1);
        check("rst_rd_en", -1, -1, -1, 32'(vram_rd_en),  32'h0);
        check("rst_vaddr", -1, -1, -1, 32'(vram_addr),   32'h0);
        check("rst_faddr", -1, -1, -1, 32'(font_addr),   32'h0);
        check("rst_fs",    -1, -1, -1, 32'(frame_start), 32'h0);
        check("rst_hsync", -1, -1, -1, 32'(hsync),       32'h1);
        check("rst_vsync", -1, -1, -1, 32'(vsync),       32'h1);
    endtask

    task automatic restart_model();
        pix_t r;
        adr_t a;
        m_hc = 0; m_vc = 0; m_f = 0; m_last_addr = '0;
        q_pix.delete();
        q_adr.delete();
        r = '{f:-1, h:-1, v:-1, rgb:8'h00, hs:1'b1, vs:1'b1, bl:1'b1};
        repeat (5) q_pix.push_back(r);
        a = '{h:-1, v:-1, rd:1'b0, addr:12'h0};
        q_adr.push_back(a);
    endtask

    // one pixel-clock cycle, entered mid-cycle (away from the active edge)
    task automatic step();
        pix_t e, p;
        adr_t a, na;
        int col, row, cx, cy, phase;
        logic vis, grid, b;
        logic [18:0] w;

        if (m_f == 3 && m_vc == 2 && m_hc == 0) mode = 1'b1;
        if (m_f == 4 && m_vc == 2 && m_hc == 0) mode = 1'b0;

        e = q_pix.pop_front();
        check("pixel", e.f, e.h, e.v, 32'({rgb_out, hsync, vsync, blank}),
              32'({e.rgb, e.hs, e.vs, e.bl}));
        for (int i = 0; i < 16; i++)
            if (probes[i].f == e.f && probes[i].h == e.h && probes[i].v == e.v)
                check("probe", e.f, e.h, e.v, 32'(rgb_out), 32'(probes[i].rgb));

        a = q_adr.pop_front();
        check("addr", m_f, a.h, a.v, 32'({vram_rd_en, vram_addr}), 32'({a.rd, a.addr}));
        if (a.h == 16 && a.v == 16)
            check("addr_spot", m_f, a.h, a.v, 32'(vram_addr), 32'd4);

        check("frame_start", m_f, m_hc, m_vc, 32'(frame_start),
              32'((m_hc == 0 && m_vc == 0) ? 1 : 0));

        if (m_hc == 0 && m_vc == 0) begin
            m_mode = mode; m_cen = cursor_en;
            m_ccol = int'(cursor_col); m_crow = int'(cursor_row);
        end

        phase = (m_f / BLINK) % 2;
        vis  = (m_hc < HA) && (m_vc < VA);
        col  = m_hc / 16; row = m_vc / 16; cx = m_hc % 16; cy = m_vc % 16;
        grid = (col < COLS) && (row < ROWS);

        p.f = m_f; p.h = m_hc; p.v = m_vc;
        p.hs = (m_hc >= HA + HFP && m_hc < HA + HFP + HSW) ? 1'b0 : 1'b1;
        p.vs = (m_vc >= VA + VFP && m_vc < VA + VFP + VSW) ? 1'b0 : 1'b1;
        p.bl = !vis;
        p.rgb = 8'h00;
        if (vis && grid) begin
            w = vram[row * COLS + col];
            if (m_mode) begin
                p.rgb = w[7:0];
            end else begin
                b = font[int'(w[7:0]) * 16 + cy][15 - cx];
                if (m_cen && col == m_ccol && row == m_crow && phase == 1) b = !b;
                if (b)
                    p.rgb = (w[18] ? 8'hE0 : 8'h00) | (w[17] ? 8'h1C : 8'h00)
                          | (w[16] ? 8'h03 : 8'h00);
            end
        end
        q_pix.push_back(p);

        if (vis && grid) m_last_addr = 12'(row * COLS + col);
        na = '{h:m_hc, v:m_vc, rd:(vis && grid), addr:m_last_addr};
        q_adr.push_back(na);

        m_hc++;
        if (m_hc == HT) begin
            m_hc = 0; m_vc++;
            if (m_vc == VT) begin m_vc = 0; m_f++; end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin vram[i] = '0; font[i] = '0; end
        vram[0] = {3'b100, 16'h0041};
        vram[1] = {3'b111, 16'h0000};
        vram[2] = {3'b010, 16'h005A};
        vram[3] = {3'b001, 16'h0042};
        vram[4] = {3'b011, 16'h0043};
        vram[5] = {3'b110, 16'h0100};
        for (int r = 0; r < 16; r++) begin
            font[16'h41 * 16 + r] = 16'h8000 >> r;
            font[16'h5A * 16 + r] = 16'hF0F0;
            font[16'h42 * 16 + r] = 16'hFFFF;
            font[16'h43 * 16 + r] = 16'hAAAA;
        end

        probes[0]  = '{f:0, h:0,  v:0,  rgb:8'hE0};
        probes[1]  = '{f:0, h:1,  v:0,  rgb:8'h00};
        probes[2]  = '{f:0, h:1,  v:1,  rgb:8'hE0};
        probes[3]  = '{f:0, h:20, v:5,  rgb:8'h00};
        probes[4]  = '{f:1, h:20, v:5,  rgb:8'h00};
        probes[5]  = '{f:2, h:20, v:5,  rgb:8'hFF};
        probes[6]  = '{f:3, h:20, v:5,  rgb:8'hFF};
        probes[7]  = '{f:3, h:40, v:3,  rgb:8'h1C};
        probes[8]  = '{f:4, h:40, v:3,  rgb:8'h5A};
        probes[9]  = '{f:4, h:0,  v:0,  rgb:8'h41};
        probes[10] = '{f:4, h:20, v:5,  rgb:8'h00};
        probes[11] = '{f:0, h:48, v:0,  rgb:8'h00};
        probes[12] = '{f:0, h:0,  v:40, rgb:8'h00};
        probes[13] = '{f:0, h:16, v:16, rgb:8'h1F};
        probes[14] = '{f:5, h:0,  v:16, rgb:8'h03};
        probes[15] = '{f:5, h:20, v:5,  rgb:8'h00};

        mode = 1'b0; cursor_en = 1'b1; cursor_col = 8'd1; cursor_row = 8'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state();

        reset = 1'b0;
        #1;
        restart_model();
        repeat (6 * FRAME + 5 * HT + 30) step();

        // reset in the middle of a visible line
        reset = 1'b1;
        #1;
        check_reset_state();
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        #1;
        restart_model();
        repeat (FRAME + 20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
